// File: rtl/mem_stage.sv
// Memory stage: direct (LD/ST) and indirect (LDI/STI) data accesses with a
// bounded ack wait, register-file writeback and condition codes.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [2:0]  req_dr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [2:0]  wb_dr,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_nzp,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StPtr, StAcc, StWb} state_e;

  // Abort on the edge that would complete the TIMEOUT-th unacknowledged cycle.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        st_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [2:0]  dr_q;
  logic [7:0]  cnt_q;
  logic [15:0] wb_data_q;
  logic [2:0]  wb_nzp_q;
  logic        err_q;
  logic        err_set;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    done      = 1'b0;
    wb_valid  = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_op[2])      err_set = 1'b1;
          else if (req_op[1]) state_d = StPtr;
          else                state_d = StAcc;
        end
      end
      StPtr: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) begin
          state_d = StAcc;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          err_set = 1'b1;
        end
      end
      StAcc: begin
        mem_req   = 1'b1;
        mem_addr  = addr_q;
        mem_we    = st_q;
        mem_wdata = st_q ? wdata_q : 16'h0000;
        if (mem_ack) begin
          state_d = StWb;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          err_set = 1'b1;
        end
      end
      StWb: begin
        done     = 1'b1;
        wb_valid = ~st_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      dr_q      <= 3'b000;
      cnt_q     <= 8'h00;
      wb_data_q <= 16'h0000;
      wb_nzp_q  <= 3'b000;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_set;
      if (req_valid && req_ready) begin
        st_q    <= req_op[0];
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        dr_q    <= req_dr;
      end
      // Indirect ops: the pointer read replaces the effective address.
      if (state_q == StPtr && mem_ack) addr_q <= mem_rdata;
      if (state_q == StAcc && mem_ack && !st_q) begin
        wb_data_q <= mem_rdata;
        wb_nzp_q  <= {mem_rdata[15], mem_rdata == 16'h0000,
                      !mem_rdata[15] && mem_rdata != 16'h0000};
      end
      if (state_d != state_q)                        cnt_q <= 8'h00;
      else if (state_q == StPtr || state_q == StAcc) cnt_q <= cnt_q + 8'h01;
    end
  end

  assign wb_dr   = dr_q;
  assign wb_data = wb_data_q;
  assign wb_nzp  = wb_nzp_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a table-driven memory that can stall or
// withhold mem_ack.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic [2:0]  req_dr = 3'b000;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_valid, done, err;
  logic [2:0]  wb_dr, wb_nzp;
  logic [15:0] wb_data;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_dr(req_dr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_dr(wb_dr),
    .wb_data(wb_data), .wb_nzp(wb_nzp), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory model: read-only table, ack after ack_delay stalled cycles.
  logic        ack_en = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt;
  int          wr_cnt = 0;
  logic [15:0] wr_addr = 16'h0, wr_data = 16'h0, rd_addr = 16'h0;
  logic [15:0] tab_a [4] = '{16'h3000, 16'h4000, 16'h3100, 16'h5000};
  logic [15:0] tab_d [4] = '{16'h8001, 16'h5000, 16'h0000, 16'h0042};

  always_comb begin
    mem_rdata = 16'hdead;
    for (int i = 0; i < 4; i++) if (tab_a[i] == mem_addr) mem_rdata = tab_d[i];
    mem_ack = ack_en && mem_req && (wait_cnt >= ack_delay);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always_ff @(posedge clk) begin
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end else begin
        rd_addr <= mem_addr;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] w,
                       input logic [2:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = w;
    req_dr    = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Observation window after an accept edge; index 1 is the first negedge.
  int          done_at, err_at, wbv_at, err_cnt, done_cnt, req_cyc, ready_low;
  int          addr_chg, gate_viol;
  logic [15:0] s_data;
  logic [2:0]  s_dr, s_nzp;

  task automatic watch(input int n);
    logic        prev_req;
    logic [15:0] prev_addr;
    done_at = 0; err_at = 0; wbv_at = 0; err_cnt = 0; done_cnt = 0;
    req_cyc = 0; ready_low = 0; addr_chg = 0; gate_viol = 0;
    prev_req = 1'b0; prev_addr = 16'h0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (done) begin done_cnt++; if (done_at == 0) done_at = i; end
      if (err) begin err_cnt++; if (err_at == 0) err_at = i; end
      if (wb_valid && wbv_at == 0) begin
        wbv_at = i; s_data = wb_data; s_dr = wb_dr; s_nzp = wb_nzp;
      end
      if (mem_req) req_cyc++;
      if (!req_ready) ready_low++;
      if (mem_req && prev_req && mem_addr != prev_addr) addr_chg++;
      if (!mem_req && (mem_we || mem_wdata != 16'h0)) gate_viol++;
      prev_req = mem_req;
      prev_addr = mem_addr;
    end
  endtask

  int wr0;

  initial begin
    // Reset state, sampled while reset is held.
    #2;
    check_eq("rst mem_req", mem_req, 0);
    check_eq("rst outputs", {done, err, wb_valid, mem_we}, 4'b0000);
    check_eq("rst mem_addr", mem_addr, 16'h0000);
    check_eq("rst wb", {wb_data, wb_dr, wb_nzp}, 22'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("rst req_ready", req_ready, 1);

    // LD with zero-wait memory, negative result
    issue(3'b000, 16'h3000, 16'h0, 3'd5);
    watch(4);
    check_eq("ld done_at", done_at, 2);
    check_eq("ld wbv_at", wbv_at, 2);
    check_eq("ld wb_data", s_data, 16'h8001);
    check_eq("ld wb_dr", s_dr, 3'd5);
    check_eq("ld wb_nzp", s_nzp, 3'b100);
    check_eq("ld pulses", {done_cnt[3:0], err_cnt[3:0], req_cyc[3:0], ready_low[3:0]}, 16'h1012);

    // STI: pointer read then write through it
    wr0 = wr_cnt;
    issue(3'b011, 16'h4000, 16'h1234, 3'd1);
    watch(5);
    check_eq("sti done_at", done_at, 3);
    check_eq("sti wbv_at", wbv_at, 0);
    check_eq("sti rd_addr", rd_addr, 16'h4000);
    check_eq("sti write", {wr_addr, wr_data}, {16'h5000, 16'h1234});
    check_eq("sti wr_cnt", wr_cnt - wr0, 1);
    check_eq("sti gating", gate_viol, 0);

    // LDI: positive result
    issue(3'b010, 16'h4000, 16'h0, 3'd2);
    watch(5);
    check_eq("ldi done_at", done_at, 3);
    check_eq("ldi rd_addr", rd_addr, 16'h5000);
    check_eq("ldi wb", {s_data, s_dr, s_nzp}, {16'h0042, 3'd2, 3'b001});

    // ST direct
    wr0 = wr_cnt;
    issue(3'b001, 16'h3000, 16'habcd, 3'd0);
    watch(4);
    check_eq("st done_at", done_at, 2);
    check_eq("st write", {wr_addr, wr_data}, {16'h3000, 16'habcd});
    check_eq("st wr_cnt", wr_cnt - wr0, 1);
    check_eq("st wbv", wbv_at, 0);

    // LD with ack delayed 3 cycles
    ack_delay = 3;
    issue(3'b000, 16'h3000, 16'h0, 3'd7);
    watch(7);
    check_eq("dly done_at", done_at, 5);
    check_eq("dly req_cyc", req_cyc, 4);
    check_eq("dly addr_chg", addr_chg, 0);
    check_eq("dly ready_low", ready_low, 5);
    ack_delay = 0;

    // Timeout: ack never comes
    ack_en = 1'b0;
    issue(3'b000, 16'h3000, 16'h0, 3'd3);
    watch(8);
    check_eq("tmo req_cyc", req_cyc, 4);
    check_eq("tmo err_at", err_at, 5);
    check_eq("tmo err_cnt", err_cnt, 1);
    check_eq("tmo done", done_cnt, 0);
    check_eq("tmo wbv", wbv_at, 0);
    check_eq("tmo ready", req_ready, 1);
    ack_en = 1'b1;

    // Illegal op
    issue(3'b101, 16'h3000, 16'h0, 3'd1);
    watch(4);
    check_eq("ill err_at", err_at, 1);
    check_eq("ill err_cnt", err_cnt, 1);
    check_eq("ill req_cyc", req_cyc, 0);
    check_eq("ill ready_low", ready_low, 0);

    // LD of zero
    issue(3'b000, 16'h3100, 16'h0, 3'd4);
    watch(4);
    check_eq("ldz wb", {s_data, s_nzp}, {16'h0000, 3'b010});

    // Reset asserted during PTR of an LDI
    ack_en = 1'b0;
    issue(3'b010, 16'h4000, 16'h0, 3'd6);
    @(negedge clk);
    check_eq("rmid mem_req pre", mem_req, 1);
    #2 rst_n = 1'b0;
    #1 check_eq("rmid mem_req", mem_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    watch(6);
    check_eq("rmid quiet", {done_cnt[7:0], err_cnt[7:0], wbv_at[7:0], req_cyc[7:0]}, 32'h0);
    check_eq("rmid ready", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
